// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the multiplier sequencer state type.
package alu_pkg;
    localparam int MUL_W  = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/adder.sv
// 16-bit unsigned adder with carry out and no carry in; the ALU's shared add resource.
module adder
    import alu_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    output logic [MUL_W-1:0] sum,
    output logic             carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 16x16->32 shift-and-add multiplier driving one shared adder, one step per clock.
// Optional data-dependent early termination is enabled by defining MUL_EARLY_EXIT_EN.
module shift_add_mul_ctrl
    import alu_pkg::*;
#(
    parameter int ITERS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);
    localparam int CW    = $clog2(ITERS + 1);
    localparam int SHIFT = MUL_W - ITERS;

    mul_state_t        state_r;
    mul_state_t        next_s;
    logic [MUL_W-1:0]  mcand_r;
    logic [MUL_W-1:0]  acc_hi_r;
    logic [MUL_W-1:0]  lo_r;
    logic [CW-1:0]     cnt_r;
    logic [PROD_W-1:0] product_r;

    logic [MUL_W-1:0]  add_b_s;
    logic [MUL_W-1:0]  sum_s;
    logic              carry_s;
    logic [PROD_W-1:0] step_s;
    logic              last_s;
    logic              early_s;

    // Partial product only enters the adder when the current multiplier bit is set.
    assign add_b_s = lo_r[0] ? mcand_r : 16'h0000;

    adder u_adder (
        .a     (acc_hi_r),
        .b     (add_b_s),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // 33-bit right shift of {carry, sum, lo}: the carry lands in acc_hi[15].
    assign step_s = {carry_s, sum_s, lo_r[MUL_W-1:1]};
    assign last_s = (cnt_r == CW'(ITERS - 1));

`ifdef MUL_EARLY_EXIT_EN
    logic [PROD_W-1:0] mask_s;

    // Detect that every multiplier bit still to be processed is zero.
    always_comb begin
        mask_s  = (32'd1 << (32'(ITERS) - 32'(cnt_r))) - 32'd1;
        early_s = (({16'h0000, lo_r} & mask_s) == 32'h0000_0000);
    end
`else
    assign early_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = start ? RUN : IDLE;
            RUN:     next_s = (early_s || last_s) ? DONE : RUN;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand latch, shift-and-add datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r   <= 16'h0000;
            acc_hi_r  <= 16'h0000;
            lo_r      <= 16'h0000;
            cnt_r     <= '0;
            product_r <= 32'h0000_0000;
        end else if (state_r == IDLE && start) begin
            mcand_r  <= a;
            lo_r     <= b;
            acc_hi_r <= 16'h0000;
            cnt_r    <= '0;
        end else if (state_r == RUN) begin
            if (early_s) begin
                product_r <= ({acc_hi_r, lo_r} >> (32'd16 - 32'(cnt_r))) >> SHIFT;
            end else begin
                {acc_hi_r, lo_r} <= step_s;
                cnt_r            <= cnt_r + CW'(1);
                if (last_s) begin
                    product_r <= step_s >> SHIFT;
                end else begin
                    product_r <= product_r;
                end
            end
        end else begin
            product_r <= product_r;
        end
    end

    assign product = product_r;
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl: directed test-plan cases plus random operands
// checked against plain-arithmetic expectations.
module tb_shift_add_mul_ctrl;
    localparam int ITERS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_mul_ctrl #(.ITERS(ITERS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected number of RUN cycles for a given multiplier.
    function automatic int exp_run(input logic [15:0] mb);
`ifdef MUL_EARLY_EXIT_EN
        int hsb;
        hsb = -1;
        for (int i = 0; i < ITERS; i++) if (mb[i]) hsb = i;
        return (hsb < 0) ? 1 : ((hsb + 2 > ITERS) ? ITERS : hsb + 2);
`else
        return (mb == 16'h0000) ? ITERS : ITERS;
`endif
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] ma, input logic [15:0] mb);
        logic [31:0] mask;
        mask = (ITERS >= 16) ? 32'h0000_FFFF : ((32'd1 << ITERS) - 32'd1);
        return 32'(ma) * (32'(mb) & mask);
    endfunction

    // One transaction. inj_kind 1 pulses a spurious start in RUN cycle inj_cyc,
    // inj_kind 2 asserts reset in that cycle and abandons the operation.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input int inj_cyc, input int inj_kind, input string tag);
        int busy_cnt;
        int cyc;
        bit got_done;
        logic [31:0] exp_p;
        exp_p = ref_mul(ta, tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        busy_cnt = 0; got_done = 1'b0; cyc = 1;
        while (!got_done && cyc < 40) begin
            if (busy && done) check({tag, "_excl"}, 32'(busy & done), 32'd0);
            if (busy) busy_cnt++;
            if (done) begin
                got_done = 1'b1;
                check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_run(tb_v) + 1));
                check({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(exp_run(tb_v)));
                check({tag, "_product"}, product, exp_p);
            end
            if (cyc == inj_cyc && inj_kind == 1) begin
                start = 1'b1; a = 16'd1; b = 16'd1;
            end
            if (cyc == inj_cyc && inj_kind == 2) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_product"}, product, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!got_done) check({tag, "_timeout"}, 32'd0, 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, product, exp_p);
    endtask

    initial begin
        int n_done;
        int last_done;
        logic [15:0] ra;
        logic [15:0] rb;

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd3, 16'd5, 0, 0, "basic");
        check("basic_value", product, 32'h0000_000F);
        run_op(16'hFFFF, 16'hFFFF, 0, 0, "maxval");
        check("maxval_value", product, 32'hFFFE_0001);
        run_op(16'd7, 16'd9, 5, 1, "ignored");
        check("ignored_value", product, 32'd63);
        run_op(16'd100, 16'd200, 8, 2, "reset_mid");
        run_op(16'd100, 16'd200, 0, 0, "after_rst");
        check("after_rst_value", product, 32'd20000);

        // start held high: back-to-back requests, one completion per ITERS+2 cycles
        @(negedge clk);
        a = 16'h1234; b = 16'h0000; start = 1'b1;
        n_done = 0; last_done = 0;
        for (int c = 1; c <= 3 * (exp_run(16'h0000) + 2); c++) begin
            @(negedge clk);
            if (busy && done) check("held_excl", 32'(busy & done), 32'd0);
            if (done) begin
                n_done++;
                check("held_product", product, 32'd0);
                if (n_done > 1) check("held_spacing", 32'(c - last_done), 32'(exp_run(16'h0000) + 2));
                last_done = c;
            end
        end
        start = 1'b0;
        check("held_count", 32'(n_done), 32'd3);
        repeat (exp_run(16'h0000) + 3) @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

`ifdef MUL_EARLY_EXIT_EN
        run_op(16'h00FF, 16'h0004, 0, 0, "early");
        check("early_value", product, 32'h0000_03FC);
        run_op(16'h00FF, 16'h0000, 0, 0, "early_zero");
`endif

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) rb = 16'h8000;
            if (i == 1) rb = 16'h0001;
            run_op(ra, rb, 0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
